// File: rtl/regression_dump_seq.sv
// End-of-run monitor: optional lossy PC trace while running, then a lossless
// register-file and data-memory dump over a single valid/ready stream.
module regression_dump_seq #(
   parameter int          DATA_W    = 32,
   parameter int          NREGS     = 32,
   parameter logic [31:0] MEM_BASE  = 32'h4000,
   parameter int          MEM_WORDS = 4,
   parameter int          TIMEOUT   = 64,
   parameter logic [31:0] HALT_INST = 32'h0000_0000,
   parameter bit          TRACE     = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run_en,
   input  logic [31:0]       inst,
   input  logic [29:0]       pc,
   output logic [4:0]        rf_addr,
   input  logic [DATA_W-1:0] rf_data,
   output logic [31:0]       mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [DATA_W-1:0] dump_data,
   output logic [1:0]        dump_kind,
   output logic [31:0]       dump_idx,
   output logic              done,
   output logic              timed_out,
   output logic [15:0]       drop_cnt,
   output logic [31:0]       cycle_count,
   output logic [2:0]        dbg_state
);

   // Stream handshake: a beat transfers on a rising edge with dump_valid=1 and
   // dump_ready=1. Dump beats hold payload/kind/idx while valid & !ready; trace
   // beats are instead overwritten next cycle and counted in drop_cnt.

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RUN      = 3'd1,
      S_DUMP_REG = 3'd2,
      S_DUMP_MEM = 3'd3,
      S_DONE     = 3'd4
   } state_e;

   localparam logic [1:0]  KIND_TRACE = 2'd0;
   localparam logic [1:0]  KIND_REG   = 2'd1;
   localparam logic [1:0]  KIND_MEM   = 2'd2;
   localparam logic [31:0] REG_LAST   = 32'(NREGS - 1);
   localparam logic [31:0] MEM_LAST   = 32'(MEM_WORDS - 1);
   localparam logic [31:0] TO_LAST    = 32'(TIMEOUT - 1);

   state_e              state_q, state_d;
   logic [31:0]         k_q, k_d;
   logic                mem_last_q, mem_last_d;
   logic [31:0]         cycle_q, cycle_d;
   logic [15:0]         drop_q, drop_d;
   logic                timed_out_q, timed_out_d;
   logic                done_q, done_d;
   logic                valid_q, valid_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [1:0]          kind_q, kind_d;
   logic [31:0]         idx_q, idx_d;

   logic                load;
   logic [31:0]         pc_byte;
   logic [DATA_W-1:0]   trace_data;
   logic [31:0]         mem_addr_w;

   assign pc_byte    = {pc, 2'b00};
   assign trace_data = DATA_W'(pc_byte);
   assign mem_addr_w = MEM_BASE + k_q;

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      mem_last_d  = mem_last_q;
      cycle_d     = cycle_q;
      drop_d      = drop_q;
      timed_out_d = timed_out_q;
      done_d      = done_q;
      valid_d     = valid_q;
      data_d      = data_q;
      kind_d      = kind_q;
      idx_d       = idx_q;
      load        = ~valid_q | dump_ready;

      case (state_q)
         S_IDLE: begin
            valid_d = 1'b0;
            if (run_en) begin
               state_d     = S_RUN;
               cycle_d     = '0;
               drop_d      = '0;
               timed_out_d = 1'b0;
               done_d      = 1'b0;
            end
         end
         S_RUN: begin
            // Any unaccepted trace beat is lost at this edge, whether it is
            // replaced by a new beat or abandoned because RUN is exiting.
            if (valid_q && !dump_ready && drop_q != 16'hFFFF)
               drop_d = drop_q + 16'd1;
            valid_d = 1'b0;
            if (run_en) begin
               cycle_d    = cycle_q + 32'd1;
               k_d        = '0;
               mem_last_d = 1'b0;
               if (inst == HALT_INST) begin
                  state_d = S_DUMP_REG;
               end else if (cycle_q == TO_LAST) begin
                  state_d     = S_DUMP_REG;
                  timed_out_d = 1'b1;
               end else if (TRACE) begin
                  valid_d = 1'b1;
                  data_d  = trace_data;
                  kind_d  = KIND_TRACE;
                  idx_d   = cycle_q;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_DUMP_REG: begin
            if (load) begin
               valid_d = 1'b1;
               data_d  = rf_data;
               kind_d  = KIND_REG;
               idx_d   = k_q;
               if (k_q == REG_LAST) begin
                  state_d = S_DUMP_MEM;
                  k_d     = '0;
               end else begin
                  k_d = k_q + 32'd1;
               end
            end
         end
         S_DUMP_MEM: begin
            // Once the last word is loaded, only its acceptance moves us on.
            if (mem_last_q) begin
               if (dump_ready) begin
                  state_d    = S_DONE;
                  valid_d    = 1'b0;
                  done_d     = 1'b1;
                  mem_last_d = 1'b0;
               end
            end else if (load) begin
               valid_d = 1'b1;
               data_d  = mem_data;
               kind_d  = KIND_MEM;
               idx_d   = mem_addr_w;
               if (k_q == MEM_LAST) mem_last_d = 1'b1;
               else                 k_d = k_q + 32'd1;
            end
         end
         S_DONE: begin
            valid_d = 1'b0;
            if (!run_en) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         mem_last_q  <= 1'b0;
         cycle_q     <= '0;
         drop_q      <= '0;
         timed_out_q <= 1'b0;
         done_q      <= 1'b0;
         valid_q     <= 1'b0;
         data_q      <= '0;
         kind_q      <= '0;
         idx_q       <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         mem_last_q  <= mem_last_d;
         cycle_q     <= cycle_d;
         drop_q      <= drop_d;
         timed_out_q <= timed_out_d;
         done_q      <= done_d;
         valid_q     <= valid_d;
         data_q      <= data_d;
         kind_q      <= kind_d;
         idx_q       <= idx_d;
      end
   end

   assign rf_addr     = (state_q == S_DUMP_REG) ? k_q[4:0] : 5'd0;
   assign mem_addr    = (state_q == S_DUMP_MEM) ? mem_addr_w : 32'd0;
   assign dump_valid  = valid_q;
   assign dump_data   = data_q;
   assign dump_kind   = kind_q;
   assign dump_idx    = idx_q;
   assign done        = done_q;
   assign timed_out   = timed_out_q;
   assign drop_cnt    = drop_q;
   assign cycle_count = cycle_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_regression_dump_seq.sv
// Bench for regression_dump_seq: random run/trace/dump scenarios checked
// against a beat-level reference model of trace and dump streams.
module tb_regression_dump_seq;

   localparam int          DATA_W    = 32;
   localparam int          NREGS     = 32;
   localparam int          MEM_WORDS = 4;
   localparam int          TIMEOUT   = 64;
   localparam logic [31:0] MEM_BASE  = 32'h4000;
   localparam logic [31:0] HALT_INST = 32'h0000_0000;
   localparam int          NBEATS    = NREGS + MEM_WORDS;
   localparam int          W         = 2 + 32 + DATA_W;

   // ---------------- clock / reset / DUT ----------------
   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              run_en = 1'b0;
   logic [31:0]       inst = 32'h13;
   logic [29:0]       pc = '0;
   logic [4:0]        rf_addr;
   logic [DATA_W-1:0] rf_data;
   logic [31:0]       mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              dump_valid;
   logic              dump_ready = 1'b1;
   logic [DATA_W-1:0] dump_data;
   logic [1:0]        dump_kind;
   logic [31:0]       dump_idx;
   logic              done;
   logic              timed_out;
   logic [15:0]       drop_cnt;
   logic [31:0]       cycle_count;
   logic [2:0]        dbg_state;

   always #5 clk = ~clk;

   regression_dump_seq #(
      .DATA_W(DATA_W), .NREGS(NREGS), .MEM_BASE(MEM_BASE), .MEM_WORDS(MEM_WORDS),
      .TIMEOUT(TIMEOUT), .HALT_INST(HALT_INST), .TRACE(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .run_en(run_en), .inst(inst), .pc(pc),
      .rf_addr(rf_addr), .rf_data(rf_data), .mem_addr(mem_addr), .mem_data(mem_data),
      .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
      .dump_kind(dump_kind), .dump_idx(dump_idx), .done(done), .timed_out(timed_out),
      .drop_cnt(drop_cnt), .cycle_count(cycle_count), .dbg_state(dbg_state)
   );

   // ---------------- register file / memory models ----------------
   logic [DATA_W-1:0] rf [NREGS];
   logic [DATA_W-1:0] dmem [16];

   always_comb rf_data = rf[rf_addr];
   always_comb begin
      mem_data = {16'hDEAD, mem_addr[15:0]};
      if (mem_addr >= MEM_BASE && mem_addr < MEM_BASE + 32'd16)
         mem_data = dmem[4'(mem_addr - MEM_BASE)];
   end

   // ---------------- scoreboard ----------------
   int checks = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];
   logic [W-1:0] got_dump[$];
   logic [W-1:0] got_trace[$];
   int stall_err = 0;
   logic stall_p = 1'b0;
   logic [W-1:0] stall_beat = '0;

   // Beats are sampled mid-cycle; valid & ready here means accepted at the next edge.
   always @(negedge clk) begin
      if (!reset) begin
         stall_p = 1'b0;
      end else begin
         if (stall_p && !(dump_valid && {dump_kind, dump_idx, dump_data} == stall_beat))
            stall_err++;
         if (dump_valid && dump_ready) got_q.push_back({dump_kind, dump_idx, dump_data});
         stall_p    = dump_valid && !dump_ready && dump_kind != 2'd0;
         stall_beat = {dump_kind, dump_idx, dump_data};
      end
   end

   // ---------------- driver tasks ----------------
   logic [29:0] pc_hist [256];
   logic        rdy_hist [256];
   int          exit_c;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_random();
      for (int i = 0; i < NREGS; i++) rf[i] = $urandom;
      for (int i = 0; i < 16; i++) dmem[i] = $urandom;
   endtask

   // rmode: 0 = ready always 1, 1 = random ready, 2 = ready low in cycles 4..6
   task automatic run_phase(input int halt_at, input int rmode, input bit seq_pc);
      logic rdy;
      run_en = 1'b1;
      tick();
      exit_c = (halt_at < TIMEOUT - 1) ? halt_at : TIMEOUT - 1;
      for (int c = 0; c <= exit_c; c++) begin
         pc_hist[c] = seq_pc ? 30'(c) : 30'($urandom);
         case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = 1'($urandom_range(0, 1));
            default: rdy = !(c >= 4 && c <= 6);
         endcase
         rdy_hist[c] = rdy;
         pc          = pc_hist[c];
         dump_ready  = rdy;
         inst        = (c == halt_at) ? HALT_INST : ($urandom | 32'h1);
         tick();
      end
      inst = 32'h13;
   endtask

   task automatic finish_dump(input bit rand_rdy, output int ticks, output bit ok);
      ok = 1'b0;
      ticks = 0;
      for (int i = 0; i < 400; i++) begin
         dump_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         ticks++;
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      dump_ready = 1'b1;
   endtask

   task automatic build_exp_dump();
      exp_q.delete();
      for (int i = 0; i < NREGS; i++) exp_q.push_back({2'd1, 32'(i), rf[i]});
      for (int j = 0; j < MEM_WORDS; j++) exp_q.push_back({2'd2, MEM_BASE + 32'(j), dmem[j]});
   endtask

   // Trace beat for RUN cycle c is offered in cycle c+1; it survives only if ready then.
   task automatic build_exp_trace(output int drops);
      logic [31:0] pcb;
      exp_q.delete();
      drops = 0;
      for (int c = 0; c < exit_c; c++) begin
         pcb = {pc_hist[c], 2'b00};
         if (rdy_hist[c + 1]) exp_q.push_back({2'd0, 32'(c), DATA_W'(pcb)});
         else                 drops++;
      end
   endtask

   function automatic void split_beats();
      got_dump.delete();
      got_trace.delete();
      foreach (got_q[i]) begin
         if (got_q[i][W-1:W-2] == 2'd0) got_trace.push_back(got_q[i]);
         else                           got_dump.push_back(got_q[i]);
      end
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [W*2+64:0] outs;
      repeat (2) tick();
      outs = {rf_addr, mem_addr, dump_valid, dump_data, dump_kind, dump_idx,
              done, timed_out, drop_cnt, cycle_count, dbg_state};
      checks++;
      if (outs !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0", outs);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_reg_preload();
      int ticks; bit ok; int drops;
      fill_random();
      rf[2] = 32'h00AB_CDEF; rf[3] = 32'h0F0F_0F0F; rf[4] = 32'hF0F0_F0F0;
      for (int i = 0; i < 4; i++) dmem[i] = 32'(i + 1);
      got_q.delete();
      run_phase(5, 0, 1'b0);
      checks++;
      if (dump_valid !== 1'b0) begin
         failures++; $display("FAIL preload_valid_after_halt got=%b exp=0", dump_valid);
      end
      finish_dump(1'b0, ticks, ok);
      checks++;
      if (!ok || ticks != NBEATS + 1) begin
         failures++; $display("FAIL preload_done_latency got=%0d ok=%b exp=%0d", ticks, ok, NBEATS + 1);
      end
      checks++;
      if (done !== 1'b1 || timed_out !== 1'b0 || dump_valid !== 1'b0) begin
         failures++; $display("FAIL preload_flags got done=%b to=%b v=%b exp 1 0 0", done, timed_out, dump_valid);
      end
      checks++;
      if (cycle_count !== 32'd6) begin
         failures++; $display("FAIL preload_cycle_count got=%0d exp=6", cycle_count);
      end
      split_beats();
      build_exp_dump();
      checks++;
      if (got_dump.size() != NBEATS) begin
         failures++; $display("FAIL preload_beat_count got=%0d exp=%0d", got_dump.size(), NBEATS);
      end
      for (int i = 0; i < NBEATS && i < got_dump.size(); i++) begin
         checks++;
         if (got_dump[i] !== exp_q[i]) begin
            failures++; $display("FAIL preload_beat[%0d] got=%h exp=%h", i, got_dump[i], exp_q[i]);
         end
      end
      build_exp_trace(drops);
      checks++;
      if (got_trace.size() != exp_q.size() || drop_cnt !== 16'(drops)) begin
         failures++;
         $display("FAIL preload_trace got n=%0d drops=%0d exp n=%0d drops=%0d",
                  got_trace.size(), drop_cnt, exp_q.size(), drops);
      end
      for (int i = 0; i < exp_q.size() && i < got_trace.size(); i++) begin
         checks++;
         if (got_trace[i] !== exp_q[i]) begin
            failures++; $display("FAIL preload_trace[%0d] got=%h exp=%h", i, got_trace[i], exp_q[i]);
         end
      end
      run_en = 1'b0;
      tick();
      checks++;
      if (done !== 1'b1 || dump_valid !== 1'b0) begin
         failures++; $display("FAIL preload_done_hold got done=%b v=%b exp 1 0", done, dump_valid);
      end
   endtask

   task automatic test_timeout();
      int ticks; bit ok;
      fill_random();
      got_q.delete();
      run_phase(1000, 0, 1'b0);
      checks++;
      if (cycle_count !== 32'(TIMEOUT) || timed_out !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("FAIL timeout_trigger got cc=%0d to=%b done=%b exp cc=%0d to=1 done=0",
                  cycle_count, timed_out, done, TIMEOUT);
      end
      finish_dump(1'b0, ticks, ok);
      split_beats();
      build_exp_dump();
      checks++;
      if (!ok || got_dump.size() != NBEATS || timed_out !== 1'b1) begin
         failures++;
         $display("FAIL timeout_dump got ok=%b n=%0d to=%b exp ok=1 n=%0d to=1", ok, got_dump.size(), timed_out, NBEATS);
      end
      for (int i = 0; i < NBEATS && i < got_dump.size(); i++) begin
         checks++;
         if (got_dump[i] !== exp_q[i]) begin
            failures++; $display("FAIL timeout_beat[%0d] got=%h exp=%h", i, got_dump[i], exp_q[i]);
         end
      end
      run_en = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      int ticks; bit ok; int drops;
      for (int it = 0; it < 3; it++) begin
         fill_random();
         got_q.delete();
         stall_err = 0;
         run_phase($urandom_range(3, 20), 1, 1'b0);
         finish_dump(1'b1, ticks, ok);
         split_beats();
         build_exp_dump();
         checks++;
         if (!ok || got_dump.size() != NBEATS || stall_err != 0) begin
            failures++;
            $display("FAIL backpressure_dump[%0d] got ok=%b n=%0d stalls_broken=%0d exp ok=1 n=%0d 0",
                     it, ok, got_dump.size(), stall_err, NBEATS);
         end
         for (int i = 0; i < NBEATS && i < got_dump.size(); i++) begin
            checks++;
            if (got_dump[i] !== exp_q[i]) begin
               failures++; $display("FAIL backpressure_beat[%0d][%0d] got=%h exp=%h", it, i, got_dump[i], exp_q[i]);
            end
         end
         build_exp_trace(drops);
         checks++;
         if (drop_cnt !== 16'(drops) || got_trace.size() != exp_q.size()) begin
            failures++;
            $display("FAIL backpressure_trace[%0d] got drops=%0d n=%0d exp drops=%0d n=%0d",
                     it, drop_cnt, got_trace.size(), drops, exp_q.size());
         end
         for (int i = 0; i < exp_q.size() && i < got_trace.size(); i++) begin
            checks++;
            if (got_trace[i] !== exp_q[i]) begin
               failures++; $display("FAIL backpressure_trace_beat[%0d][%0d] got=%h exp=%h", it, i, got_trace[i], exp_q[i]);
            end
         end
         run_en = 1'b0;
         tick();
      end
   endtask

   task automatic test_trace_drops();
      int ticks; bit ok; int drops;
      fill_random();
      got_q.delete();
      run_phase(10, 2, 1'b1);
      checks++;
      if (drop_cnt !== 16'd3) begin
         failures++; $display("FAIL trace_drop_count got=%0d exp=3", drop_cnt);
      end
      finish_dump(1'b0, ticks, ok);
      split_beats();
      build_exp_trace(drops);
      checks++;
      if (!ok || drops != 3 || got_trace.size() != 7) begin
         failures++; $display("FAIL trace_accepted got ok=%b n=%0d exp ok=1 n=7", ok, got_trace.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_trace.size(); i++) begin
         checks++;
         if (got_trace[i] !== exp_q[i]) begin
            failures++; $display("FAIL trace_beat[%0d] got=%h exp=%h", i, got_trace[i], exp_q[i]);
         end
      end
      run_en = 1'b0;
      tick();
   endtask

   task automatic test_simultaneous();
      int ticks; bit ok; int n_dump;
      fill_random();
      got_q.delete();
      run_phase(TIMEOUT - 1, 0, 1'b0);
      checks++;
      if (timed_out !== 1'b0 || cycle_count !== 32'(TIMEOUT)) begin
         failures++; $display("FAIL halt_on_timeout got to=%b cc=%0d exp to=0 cc=%0d", timed_out, cycle_count, TIMEOUT);
      end
      finish_dump(1'b0, ticks, ok);
      split_beats();
      checks++;
      if (!ok || got_dump.size() != NBEATS || timed_out !== 1'b0) begin
         failures++; $display("FAIL halt_on_timeout_dump got ok=%b n=%0d to=%b", ok, got_dump.size(), timed_out);
      end
      run_en = 1'b0;
      tick();
      // abort: drop run_en in RUN cycle 7
      got_q.delete();
      run_en = 1'b1;
      tick();
      for (int c = 0; c < 7; c++) begin
         pc = 30'($urandom);
         inst = $urandom | 32'h1;
         tick();
      end
      run_en = 1'b0;
      tick();
      checks++;
      if (cycle_count !== 32'd7 || dump_valid !== 1'b0 || done !== 1'b0) begin
         failures++; $display("FAIL abort_state got cc=%0d v=%b done=%b exp 7 0 0", cycle_count, dump_valid, done);
      end
      inst = HALT_INST;
      repeat (10) tick();
      inst = 32'h13;
      split_beats();
      n_dump = got_dump.size();
      checks++;
      if (n_dump != 0 || cycle_count !== 32'd7 || dump_valid !== 1'b0) begin
         failures++; $display("FAIL abort_no_dump got n=%0d cc=%0d v=%b exp 0 7 0", n_dump, cycle_count, dump_valid);
      end
   endtask

   task automatic test_reset_mid_dump();
      int ticks; bit ok; bit reached;
      logic [W*2+64:0] outs;
      fill_random();
      got_q.delete();
      run_phase(4, 0, 1'b1);
      reached = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (dump_valid && dump_kind == 2'd2) begin
            reached = 1'b1;
            break;
         end
      end
      checks++;
      if (!reached) begin
         failures++; $display("FAIL reset_reach_mem got kind=%0d v=%b exp kind=2 v=1", dump_kind, dump_valid);
      end
      reset = 1'b0;
      run_en = 1'b0;
      #1;
      outs = {rf_addr, mem_addr, dump_valid, dump_data, dump_kind, dump_idx,
              done, timed_out, drop_cnt, cycle_count, dbg_state};
      checks++;
      if (outs !== '0) begin
         failures++; $display("FAIL reset_mid_dump_outputs got=%h exp=0", outs);
      end
      repeat (2) tick();
      reset = 1'b1;
      tick();
      fill_random();
      got_q.delete();
      run_phase(6, 0, 1'b0);
      finish_dump(1'b0, ticks, ok);
      split_beats();
      build_exp_dump();
      checks++;
      if (!ok || got_dump.size() != NBEATS || done !== 1'b1) begin
         failures++; $display("FAIL rearm_dump got ok=%b n=%0d done=%b exp ok=1 n=%0d done=1", ok, got_dump.size(), done, NBEATS);
      end
      for (int i = 0; i < NBEATS && i < got_dump.size(); i++) begin
         checks++;
         if (got_dump[i] !== exp_q[i]) begin
            failures++; $display("FAIL rearm_beat[%0d] got=%h exp=%h", i, got_dump[i], exp_q[i]);
         end
      end
      run_en = 1'b0;
      tick();
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      test_reset();
      test_reg_preload();
      test_timeout();
      test_back_to_back();
      test_trace_drops();
      test_simultaneous();
      test_reset_mid_dump();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog time limit reached at %0t", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
